// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control sequencer for the MIPS core.
// Steps each instruction through fetch / decode / execute / memory / writeback
// and drives the datapath control lines from the current state.
// Optional feature macro: MC_HALF_LOAD_EN (lh/lhu halfword loads).
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       half,
  output logic       half_unsigned,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
`ifdef MC_HALF_LOAD_EN
  localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OP_LHU   = 6'b100101;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10
  } state_t;

  state_t          state_q;
  state_t          state_d;
  state_t          dec_target;
  logic            op_legal;
  logic [OP_W-1:0] op_q;

  assign state = state_q;

  // State register; reset forces FETCH without waiting for a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode capture; only the DECODE cycle samples op_code
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
    end else if (state_q == S_DECODE) begin
      op_q <= op_code;
    end
  end

  // Opcode decode: dispatch target and legality of the live op_code
  always_comb begin
    dec_target = S_FETCH;
    op_legal   = 1'b1;
    unique case (op_code)
      OP_RTYPE: dec_target = S_R_EXEC;
      OP_ADDI:  dec_target = S_ADDI_EXEC;
      OP_LW,
      OP_SW:    dec_target = S_MEM_ADDR;
      OP_BEQ:   dec_target = S_BRANCH;
`ifdef MC_HALF_LOAD_EN
      OP_LH,
      OP_LHU:   dec_target = S_MEM_ADDR;
`endif
      default: begin
        dec_target = S_FETCH;
        op_legal   = 1'b0;
      end
    endcase
  end

  // Next-state logic; memory states hold until mem_ready
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = dec_target;
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Datapath control outputs decoded from the current state
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    half          = 1'b0;
    half_unsigned = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // Loads are blocked while reset is held so no PC/IR update escapes
        ir_write  = mem_ready & reset_n;
        pc_write  = mem_ready & reset_n;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~op_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: begin
        alu_src_b = 2'b00;
      end
    endcase
`ifdef MC_HALF_LOAD_EN
    // Halfword select follows the latched load opcode through the load path
    if ((state_q == S_MEM_ADDR) || (state_q == S_MEM_READ) || (state_q == S_MEM_WB)) begin
      half          = (op_q == OP_LH) || (op_q == OP_LHU);
      half_unsigned = (op_q == OP_LHU);
    end
`endif
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes the expected control
// vector for each cycle, a monitor pops and compares on the falling edge.
module tb_mc_control_fsm;

  logic       clk;
  logic       reset_n;
  logic [5:0] op_code;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_source, i_or_d, ir_write;
  logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       half, half_unsigned, illegal_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [21:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  logic [21:0] act;
  assign act = {state, pc_write, pc_write_cond, pc_source, i_or_d, ir_write,
                mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, half, half_unsigned, illegal_op};

  mc_control_fsm dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .op_code       (op_code),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .half          (half),
    .half_unsigned (half_unsigned),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector for a state, taken from the per-state control table
  function automatic logic [21:0] ex(input int st, input bit rdy, input bit ill,
                                     input bit h, input bit hu);
    logic pw, pwc, psrc, iod, irw, mr, mw, m2r, rd, rw, asa;
    logic [1:0] asb, aop;
    {pw, pwc, psrc, iod, irw, mr, mw, m2r, rd, rw, asa} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      0: begin mr = 1'b1; asb = 2'b01; irw = rdy; pw = rdy; end
      1: asb = 2'b11;
      2: begin asa = 1'b1; asb = 2'b10; end
      3: begin mr = 1'b1; iod = 1'b1; end
      4: begin rw = 1'b1; m2r = 1'b1; end
      5: begin mw = 1'b1; iod = 1'b1; end
      6: begin asa = 1'b1; aop = 2'b10; end
      7: begin rw = 1'b1; rd = 1'b1; end
      8: begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 1'b1; end
      9: begin asa = 1'b1; asb = 2'b10; end
      10: rw = 1'b1;
      default: ;
    endcase
    return {4'(st), pw, pwc, psrc, iod, irw, mr, mw, m2r, rd, rw, asa,
            asb, aop, h, hu, ill};
  endfunction

  task automatic check(input string nm, input logic [21:0] a, input logic [21:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected in that cycle
  task automatic step(input string nm, input bit rdy, input logic [5:0] op,
                      input logic [21:0] e);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    op_code   = op;
    sb.push_back('{name: nm, exp: e});
  endtask

  // Monitor: one response per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t ent;
      ent = sb.pop_front();
      check(ent.name, act, ent.exp);
    end
  end

  initial begin
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    op_code   = 6'b000000;
    #2;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("reset_outputs", act, ex(0, 1'b0, 1'b0, 1'b0, 1'b0));
    #9;
    mem_ready = 1'b0;
    reset_n   = 1'b1;

    // R-type, with op_code wiggled outside DECODE
    step("r_fetch",  1'b1, 6'b111111, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("r_decode", 1'b1, 6'b000000, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("r_exec",   1'b1, 6'b111111, ex(6, 1'b0, 1'b0, 1'b0, 1'b0));
    step("r_wb",     1'b0, 6'b101011, ex(7, 1'b0, 1'b0, 1'b0, 1'b0));

    // lw with two wait cycles in MEM_READ
    step("lw_fetch",  1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("lw_decode", 1'b0, 6'b100011, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("lw_addr",   1'b0, 6'b101011, ex(2, 1'b0, 1'b0, 1'b0, 1'b0));
    step("lw_rd0",    1'b0, 6'b000000, ex(3, 1'b0, 1'b0, 1'b0, 1'b0));
    step("lw_rd1",    1'b0, 6'b000000, ex(3, 1'b0, 1'b0, 1'b0, 1'b0));
    step("lw_rd2",    1'b1, 6'b000000, ex(3, 1'b0, 1'b0, 1'b0, 1'b0));
    step("lw_wb",     1'b0, 6'b000000, ex(4, 1'b0, 1'b0, 1'b0, 1'b0));

    // sw with one wait cycle in FETCH
    step("sw_fetch_wait", 1'b0, 6'b000000, ex(0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("sw_fetch",      1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("sw_decode",     1'b1, 6'b101011, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("sw_addr",       1'b1, 6'b100011, ex(2, 1'b0, 1'b0, 1'b0, 1'b0));
    step("sw_write",      1'b1, 6'b000000, ex(5, 1'b0, 1'b0, 1'b0, 1'b0));

    // beq
    step("beq_fetch",  1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("beq_decode", 1'b1, 6'b000100, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("beq_branch", 1'b1, 6'b000000, ex(8, 1'b0, 1'b0, 1'b0, 1'b0));

    // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH
    step("ill_fetch",  1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("ill_decode", 1'b1, 6'b111111, ex(1, 1'b0, 1'b1, 1'b0, 1'b0));

    // lhu: load path with halfword selects, or illegal without the feature
    step("lhu_fetch",  1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef MC_HALF_LOAD_EN
    step("lhu_decode", 1'b1, 6'b100101, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("lhu_addr",   1'b1, 6'b000000, ex(2, 1'b0, 1'b0, 1'b1, 1'b1));
    step("lhu_rd",     1'b1, 6'b000000, ex(3, 1'b0, 1'b0, 1'b1, 1'b1));
    step("lhu_wb",     1'b1, 6'b000000, ex(4, 1'b0, 1'b0, 1'b1, 1'b1));
    step("lh_fetch",   1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("lh_decode",  1'b1, 6'b100001, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("lh_addr",    1'b1, 6'b000000, ex(2, 1'b0, 1'b0, 1'b1, 1'b0));
    step("lh_rd",      1'b1, 6'b000000, ex(3, 1'b0, 1'b0, 1'b1, 1'b0));
    step("lh_wb",      1'b1, 6'b000000, ex(4, 1'b0, 1'b0, 1'b1, 1'b0));
`else
    step("lhu_decode", 1'b1, 6'b100101, ex(1, 1'b0, 1'b1, 1'b0, 1'b0));
    step("lh_fetch",   1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("lh_decode",  1'b1, 6'b100001, ex(1, 1'b0, 1'b1, 1'b0, 1'b0));
`endif

    // sw stalled in MEM_WRITE, then reset lands between clock edges
    step("rst_fetch",  1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("rst_decode", 1'b1, 6'b101011, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("rst_addr",   1'b0, 6'b000000, ex(2, 1'b0, 1'b0, 1'b0, 1'b0));
    step("rst_write",  1'b0, 6'b000000, ex(5, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #3;
    check("write_held", act, ex(5, 1'b0, 1'b0, 1'b0, 1'b0));
    reset_n = 1'b0;
    #1;
    check("async_reset_in_write", act, ex(0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    mem_ready = 1'b0;
    reset_n   = 1'b1;

    // First instruction after reset: addi
    step("post_fetch",  1'b1, 6'b000000, ex(0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("addi_decode", 1'b1, 6'b001000, ex(1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("addi_exec",   1'b1, 6'b000000, ex(9, 1'b0, 1'b0, 1'b0, 1'b0));
    step("addi_wb",     1'b1, 6'b000000, ex(10, 1'b0, 1'b0, 1'b0, 1'b0));
    step("addi_next",   1'b0, 6'b000000, ex(0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
